// File: rtl/ps2_tx_scheduler_pkg.sv
// Purpose: shared types for the PS/2 device-to-host transmit scheduler.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package ps2_tx_scheduler_pkg;

  // Scheduler states; HOST is the yield-to-host state
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BUS = 3'd1,
    ST_START    = 3'd2,
    ST_SEND     = 3'd3,
    ST_GAP      = 3'd4,
    ST_HOST     = 3'd5
  } state_t;

  // Which requester owns the next frame
  typedef enum logic [2:0] {
    SRC_NONE   = 3'd0,
    SRC_RETRY  = 3'd1,
    SRC_RESEND = 3'd2,
    SRC_RSP    = 3'd3,
    SRC_KEY    = 3'd4
  } src_t;

  // Fixed priority: aborted frame > host resend > response > scan code
  function automatic src_t pick_src(input logic retry, input logic pend_resend,
                                    input logic rsp_vld, input logic key_vld);
    if (retry)            return SRC_RETRY;
    else if (pend_resend) return SRC_RESEND;
    else if (rsp_vld)     return SRC_RSP;
    else if (key_vld)     return SRC_KEY;
    else                  return SRC_NONE;
  endfunction

endpackage

// File: rtl/ps2_tx_scheduler_line_monitor.sv
// Purpose: synchronise the raw PS/2 lines and time how long the bus has been idle.
// Latency: 2 cycles line-to-decision; idle_done after IDLE_COUNT consecutive idle cycles.
// Backpressure: none; free-running observer, counter cleared by the scheduler.
module ps2_tx_scheduler_line_monitor
  import ps2_tx_scheduler_pkg::*;
#(
  parameter int IDLE_COUNT = 2500,
  parameter int CNT_WIDTH  = 12
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  input  logic i_cnt_clr,
  output logic o_bus_idle_done,
  output logic o_host_rts_det
);

  localparam logic [CNT_WIDTH-1:0] LP_IDLE_LAST = CNT_WIDTH'(IDLE_COUNT - 1);

  logic [1:0]           r_clk_sync;
  logic [1:0]           r_dat_sync;
  logic [CNT_WIDTH-1:0] r_idle_cnt;
  logic                 w_bus_idle;

  assign w_bus_idle      = r_clk_sync[1] & r_dat_sync[1];
  assign o_host_rts_det  = r_clk_sync[1] & ~r_dat_sync[1];
  assign o_bus_idle_done = w_bus_idle && (r_idle_cnt >= LP_IDLE_LAST);

  // Two-flop synchronisers; reset to the released (high) line level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
    end
  end

  // Consecutive-idle counter: any low line restarts it, saturates instead of wrapping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idle_cnt <= '0;
    end else if (i_cnt_clr || !w_bus_idle) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != '1) begin
      r_idle_cnt <= r_idle_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ps2_tx_scheduler.sv
// Purpose: arbitrate response/scan-code bytes onto the PS/2 frame transmitter, yield to host, retransmit.
// Latency: tx_start 1 cycle after START, START after IDLE_COUNT idle cycles; GAP_COUNT cycles after each frame.
// Backpressure: sources hold *_valid until a 1-cycle *_ready pulse; frame transmitter paced by tx_done/tx_abort.
module ps2_tx_scheduler
  import ps2_tx_scheduler_pkg::*;
#(
  parameter int IDLE_COUNT = 2500,
  parameter int GAP_COUNT  = 500,
  parameter int CNT_WIDTH  = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       resend_req,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_data,
  output logic       rsp_ready,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  output logic       key_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  input  logic       tx_abort,
  output logic       host_rts
);

  localparam logic [CNT_WIDTH-1:0] LP_GAP_LAST = CNT_WIDTH'(GAP_COUNT - 1);

  state_t               r_state;
  state_t               w_next;
  src_t                 w_src;
  logic                 w_cnt_clr;
  logic                 w_bus_idle_done;
  logic                 w_host_rts_det;
  logic [7:0]           r_tx_data;
  logic                 r_tx_start;
  logic [7:0]           r_last_byte;
  logic                 r_last_valid;
  logic                 r_retry;
  logic                 r_pend_resend;
  logic [CNT_WIDTH-1:0] r_gap_cnt;

  ps2_tx_scheduler_line_monitor #(
    .IDLE_COUNT(IDLE_COUNT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_line_monitor (
    .i_clk          (clk),
    .i_rst_n        (rst),
    .i_ps2_clk      (ps2_clk_in),
    .i_ps2_data     (ps2_data_in),
    .i_cnt_clr      (w_cnt_clr),
    .o_bus_idle_done(w_bus_idle_done),
    .o_host_rts_det (w_host_rts_det)
  );

  assign w_src    = pick_src(r_retry, r_pend_resend, rsp_valid, key_valid);
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state: host request-to-send pre-empts everything except an in-flight frame
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_host_rts_det)         w_next = ST_HOST;
        else if (w_src != SRC_NONE) w_next = ST_WAIT_BUS;
      end
      ST_WAIT_BUS: begin
        if (w_host_rts_det)       w_next = ST_HOST;
        else if (w_bus_idle_done) w_next = ST_START;
      end
      ST_START: w_next = (w_src != SRC_NONE) ? ST_SEND : ST_IDLE;
      ST_SEND: begin
        if (tx_abort)     w_next = ST_IDLE;
        else if (tx_done) w_next = ST_GAP;
      end
      ST_GAP: begin
        if (w_host_rts_det)              w_next = ST_HOST;
        else if (r_gap_cnt == LP_GAP_LAST) w_next = ST_IDLE;
      end
      ST_HOST: if (w_bus_idle_done) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: ready pulses only in START, idle timer runs only while waiting
  always_comb begin
    rsp_ready = (r_state == ST_START) && (w_src == SRC_RSP);
    key_ready = (r_state == ST_START) && (w_src == SRC_KEY);
    host_rts  = (r_state == ST_HOST);
    w_cnt_clr = !((r_state == ST_WAIT_BUS) || (r_state == ST_HOST));
  end

  // Byte selection, launch pulse, retry/resend bookkeeping and gap timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_data     <= 8'h00;
      r_tx_start    <= 1'b0;
      r_last_byte   <= 8'h00;
      r_last_valid  <= 1'b0;
      r_retry       <= 1'b0;
      r_pend_resend <= 1'b0;
      r_gap_cnt     <= '0;
    end else begin
      r_tx_start <= (r_state == ST_START) && (w_src != SRC_NONE);

      if (r_state == ST_START) begin
        case (w_src)
          SRC_RSP:    r_tx_data <= rsp_data;
          SRC_KEY:    r_tx_data <= key_data;
          SRC_RESEND: r_tx_data <= r_last_byte;
          default:    r_tx_data <= r_tx_data;
        endcase
      end

      // A resend request arriving in the serving cycle is a new request and is kept
      if (resend_req && r_last_valid)
        r_pend_resend <= 1'b1;
      else if ((r_state == ST_START) && (w_src == SRC_RESEND))
        r_pend_resend <= 1'b0;

      if (r_state == ST_SEND) begin
        if (tx_abort) begin
          r_retry <= 1'b1;
        end else if (tx_done) begin
          r_last_byte  <= r_tx_data;
          r_last_valid <= 1'b1;
          r_retry      <= 1'b0;
        end
      end

      if (r_state != ST_GAP)
        r_gap_cnt <= '0;
      else if (r_gap_cnt != '1)
        r_gap_cnt <= r_gap_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
